coreriscv_axi4_tile_link_enqueuer: RTL
======================================

// Module: coreriscv_axi4_tile_link_enqueuer
// PURPOSE
//  Decoupling buffer on the uncached TileLink port, downstream of the memory interconnect's io_out_0.
//  Independent FIFOs on acquire (interconnect->memory) and grant (memory->interconnect) cut all ready/valid
//  combinational paths and absorb back-pressure. Also reports per-channel occupancy for debug/perf.
// PARAMETERS
//  ACQ_DEPTH  2  acquire FIFO entries, legal range 1..16, need not be a power of two
//  GNT_DEPTH  2  grant FIFO entries, legal range 1..16, need not be a power of two
// PORTS
//  clk                            in   1    single clock for all logic
//  reset                          in   1    synchronous, active-high
//  io_in_acquire_ready            out  1    acquire FIFO not full
//  io_in_acquire_valid            in   1    upstream acquire valid
//  io_in_acquire_bits_*           in   111  addr_block[25:0] client_xact_id[1:0] addr_beat[2:0] is_builtin_type a_type[2:0] union[11:0] data[63:0]
//  io_in_grant_ready              in   1    upstream accepts grant
//  io_in_grant_valid              out  1    grant FIFO not empty
//  io_in_grant_bits_*             out  75   addr_beat[2:0] client_xact_id[1:0] manager_xact_id is_builtin_type g_type[3:0] data[63:0]
//  io_out_acquire_ready           in   1    memory side accepts acquire
//  io_out_acquire_valid           out  1    acquire FIFO not empty
//  io_out_acquire_bits_*          out  111  same fields as io_in_acquire_bits_*
//  io_out_grant_ready             out  1    grant FIFO not full
//  io_out_grant_valid             in   1    memory side grant valid
//  io_out_grant_bits_*            in   75   same fields as io_in_grant_bits_*
//  io_acq_count                   out  5    acquire FIFO occupancy, 0..ACQ_DEPTH
//  io_gnt_count                   out  5    grant FIFO occupancy, 0..GNT_DEPTH
// BEHAVIOUR
//  - Both FIFOs are identical: enq fires on valid&&ready at the input side, deq fires on valid&&ready at the
//    output side; fields travel bit-exact, and order is preserved per channel.
//  - Neither flow-through nor pipe: an item enqueued in cycle N is first visible at the output in N+1.
//    ready = (count != DEPTH) and never depends on the downstream ready. valid = (count != 0).
//  - Full FIFO with deq in the same cycle: ready stays 0 that cycle, so no enq. Bubble-free full-rate
//    streaming needs DEPTH>=2. DEPTH=1 gives half throughput, which is legal.
//  - Empty FIFO: deq is impossible, and an enq that cycle lands at count=1.
//  - Enq and deq in the same cycle with 0<count<DEPTH: count is unchanged and both pointers advance.
//  - Pointers wrap from DEPTH-1 to 0 by explicit compare, not modulo 2^n. count is a saturating-free
//    counter of width 5.
//  - Output bits are forced to 0 whenever the FIFO is empty, so the values are deterministic after reset.
//    Storage RAM is not reset.
//  - Reset (sync): on the first clk edge with reset=1, count and pointers go to 0. While reset is high,
//    every ready and valid output is held 0 combinationally and no enq/deq takes effect.
//  - Reset values: all *_valid=0, all *_ready=0 while reset is high and 1 the cycle after reset releases,
//    all *_bits=0, io_acq_count=0, io_gnt_count=0.
//  - Reset mid-transfer: any queued beats, including partial multi-beat bursts, are discarded. There is no
//    drain. Upstream and downstream are reset together.
//  - Multi-beat acquires/grants (addr_beat 0..7) need no special handling; beats are independent entries.
// STRUCTURE
//  - Shared package coreriscv_axi4_tl_pkg holds the field widths (ADDR_BLOCK_W=26, XACT_ID_W=2, BEAT_W=3,
//    ATYPE_W=3, GTYPE_W=4, UNION_W=12, DATA_W=64) and the derived ACQ_W=111, GNT_W=75.
//  - One sub-module, coreriscv_axi4_tl_queue #(WIDTH, DEPTH): generic register-array FIFO with
//    enq/deq/count. It is instantiated twice. The top level does only field pack/unpack.
// TESTING
//  1. Reset: assert reset for 3 clk while io_in_acquire_valid=1 -> no enq. All valid=0, bits=0, counts=0.
//     Readies go 1 on the first cycle after release.
//  2. Single acquire addr_block=26'h2000040, data=64'hDEADBEEF_00000001, out_ready=1 -> out_valid=1
//     exactly one cycle later with identical bits, and io_acq_count goes 1->0.
//  3. Back-pressure: io_out_acquire_ready=0, send 3 beats (DEPTH=2) -> 2 accepted, in_ready=0 and count=2.
//     Release ready -> beats emerge in order with beat 0,1, then the third is accepted.
//  4. Streaming: 8-beat grant burst (addr_beat 0..7), both readies=1 -> 8 grants delivered in 8
//     consecutive cycles after 1-cycle latency, and io_gnt_count stays at 1.
//  5. Simultaneous enq/deq at count=1 -> count stays 1. At count=DEPTH with deq -> ready=0 and no enq.
//     Pointer wrap verified with DEPTH=3 over 10 items.
//  6. Reset mid-burst with 2 acquire and 2 grant entries queued -> next cycle counts=0, valids=0, and no
//     stale entry reappears afterwards.

Source files
------------

// File: rtl/coreriscv_axi4_tl_pkg.sv
// Shared TileLink field widths and packed beat layouts for the uncached
// acquire/grant channels. All field ordering (MSB first) lives here, so the
// top level and any future consumer pack beats identically.
package coreriscv_axi4_tl_pkg;

  localparam int ADDR_BLOCK_W  = 26;
  localparam int XACT_ID_W     = 2;
  localparam int MGR_XACT_ID_W = 1;
  localparam int BEAT_W        = 3;
  localparam int ATYPE_W       = 3;
  localparam int GTYPE_W       = 4;
  localparam int UNION_W       = 12;
  localparam int DATA_W        = 64;
  localparam int COUNT_W       = 5;

  typedef struct packed {
    logic [ADDR_BLOCK_W-1:0] addr_block;
    logic [XACT_ID_W-1:0]    client_xact_id;
    logic [BEAT_W-1:0]       addr_beat;
    logic                    is_builtin_type;
    logic [ATYPE_W-1:0]      a_type;
    logic [UNION_W-1:0]      union_bits;
    logic [DATA_W-1:0]       data;
  } acquire_t;

  typedef struct packed {
    logic [BEAT_W-1:0]        addr_beat;
    logic [XACT_ID_W-1:0]     client_xact_id;
    logic [MGR_XACT_ID_W-1:0] manager_xact_id;
    logic                     is_builtin_type;
    logic [GTYPE_W-1:0]       g_type;
    logic [DATA_W-1:0]        data;
  } grant_t;

  localparam int ACQ_W = $bits(acquire_t);  // 111
  localparam int GNT_W = $bits(grant_t);    // 75

endpackage

// File: rtl/coreriscv_axi4_tl_queue.sv
// Generic register-array FIFO (neither flow-through nor pipe).
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   enq_valid/ready/data  input side; ready = not full, independent of deq_ready
//   deq_valid/ready/data  output side; valid = not empty, data forced to 0 when empty
//   count                 occupancy 0..DEPTH
// DEPTH may be any value 1..16; pointers wrap by explicit compare.
module coreriscv_axi4_tl_queue
  import coreriscv_axi4_tl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  logic [WIDTH-1:0]   enq_data,
  output logic               deq_valid,
  input  logic               deq_ready,
  output logic [WIDTH-1:0]   deq_data,
  output logic [COUNT_W-1:0] count
);

  localparam int                 PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]   LAST  = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] FULL  = COUNT_W'(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [COUNT_W-1:0] cnt;
  logic               enq_fire, deq_fire;

  // Handshakes are blanked while reset is high so nothing moves during reset.
  assign enq_ready = !reset && (cnt != FULL);
  assign deq_valid = !reset && (cnt != '0);
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;
  assign deq_data  = deq_valid ? mem[rd_ptr] : '0;
  assign count     = cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq_fire) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      unique case ({enq_fire, deq_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; deq_data is masked when empty,
  // so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/coreriscv_axi4_tile_link_enqueuer.sv
// Decoupling buffer on the uncached TileLink port: one FIFO on acquire
// (interconnect -> memory), one on grant (memory -> interconnect). Cuts all
// ready/valid combinational paths and reports per-channel occupancy.
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   io_in_acquire_*         acquire from interconnect (enq side)
//   io_out_acquire_*        acquire to memory (deq side)
//   io_out_grant_*          grant from memory (enq side)
//   io_in_grant_*           grant to interconnect (deq side)
//   io_acq_count/gnt_count  FIFO occupancy
// This level only packs/unpacks fields around the two queue instances.
module coreriscv_axi4_tile_link_enqueuer
  import coreriscv_axi4_tl_pkg::*;
#(
  parameter int ACQ_DEPTH = 2,
  parameter int GNT_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  // acquire, upstream
  output logic                     io_in_acquire_ready,
  input  logic                     io_in_acquire_valid,
  input  logic [ADDR_BLOCK_W-1:0]  io_in_acquire_bits_addr_block,
  input  logic [XACT_ID_W-1:0]     io_in_acquire_bits_client_xact_id,
  input  logic [BEAT_W-1:0]        io_in_acquire_bits_addr_beat,
  input  logic                     io_in_acquire_bits_is_builtin_type,
  input  logic [ATYPE_W-1:0]       io_in_acquire_bits_a_type,
  input  logic [UNION_W-1:0]       io_in_acquire_bits_union,
  input  logic [DATA_W-1:0]        io_in_acquire_bits_data,
  // grant, upstream
  input  logic                     io_in_grant_ready,
  output logic                     io_in_grant_valid,
  output logic [BEAT_W-1:0]        io_in_grant_bits_addr_beat,
  output logic [XACT_ID_W-1:0]     io_in_grant_bits_client_xact_id,
  output logic [MGR_XACT_ID_W-1:0] io_in_grant_bits_manager_xact_id,
  output logic                     io_in_grant_bits_is_builtin_type,
  output logic [GTYPE_W-1:0]       io_in_grant_bits_g_type,
  output logic [DATA_W-1:0]        io_in_grant_bits_data,
  // acquire, downstream
  input  logic                     io_out_acquire_ready,
  output logic                     io_out_acquire_valid,
  output logic [ADDR_BLOCK_W-1:0]  io_out_acquire_bits_addr_block,
  output logic [XACT_ID_W-1:0]     io_out_acquire_bits_client_xact_id,
  output logic [BEAT_W-1:0]        io_out_acquire_bits_addr_beat,
  output logic                     io_out_acquire_bits_is_builtin_type,
  output logic [ATYPE_W-1:0]       io_out_acquire_bits_a_type,
  output logic [UNION_W-1:0]       io_out_acquire_bits_union,
  output logic [DATA_W-1:0]        io_out_acquire_bits_data,
  // grant, downstream
  output logic                     io_out_grant_ready,
  input  logic                     io_out_grant_valid,
  input  logic [BEAT_W-1:0]        io_out_grant_bits_addr_beat,
  input  logic [XACT_ID_W-1:0]     io_out_grant_bits_client_xact_id,
  input  logic [MGR_XACT_ID_W-1:0] io_out_grant_bits_manager_xact_id,
  input  logic                     io_out_grant_bits_is_builtin_type,
  input  logic [GTYPE_W-1:0]       io_out_grant_bits_g_type,
  input  logic [DATA_W-1:0]        io_out_grant_bits_data,
  // occupancy
  output logic [COUNT_W-1:0]       io_acq_count,
  output logic [COUNT_W-1:0]       io_gnt_count
);

  acquire_t acq_enq, acq_deq;
  grant_t   gnt_enq, gnt_deq;

  assign acq_enq = '{
    addr_block:      io_in_acquire_bits_addr_block,
    client_xact_id:  io_in_acquire_bits_client_xact_id,
    addr_beat:       io_in_acquire_bits_addr_beat,
    is_builtin_type: io_in_acquire_bits_is_builtin_type,
    a_type:          io_in_acquire_bits_a_type,
    union_bits:      io_in_acquire_bits_union,
    data:            io_in_acquire_bits_data
  };

  assign gnt_enq = '{
    addr_beat:       io_out_grant_bits_addr_beat,
    client_xact_id:  io_out_grant_bits_client_xact_id,
    manager_xact_id: io_out_grant_bits_manager_xact_id,
    is_builtin_type: io_out_grant_bits_is_builtin_type,
    g_type:          io_out_grant_bits_g_type,
    data:            io_out_grant_bits_data
  };

  coreriscv_axi4_tl_queue #(.WIDTH(ACQ_W), .DEPTH(ACQ_DEPTH)) u_acq_q (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (io_in_acquire_valid),
    .enq_ready (io_in_acquire_ready),
    .enq_data  (acq_enq),
    .deq_valid (io_out_acquire_valid),
    .deq_ready (io_out_acquire_ready),
    .deq_data  (acq_deq),
    .count     (io_acq_count)
  );

  coreriscv_axi4_tl_queue #(.WIDTH(GNT_W), .DEPTH(GNT_DEPTH)) u_gnt_q (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (io_out_grant_valid),
    .enq_ready (io_out_grant_ready),
    .enq_data  (gnt_enq),
    .deq_valid (io_in_grant_valid),
    .deq_ready (io_in_grant_ready),
    .deq_data  (gnt_deq),
    .count     (io_gnt_count)
  );

  assign io_out_acquire_bits_addr_block      = acq_deq.addr_block;
  assign io_out_acquire_bits_client_xact_id  = acq_deq.client_xact_id;
  assign io_out_acquire_bits_addr_beat       = acq_deq.addr_beat;
  assign io_out_acquire_bits_is_builtin_type = acq_deq.is_builtin_type;
  assign io_out_acquire_bits_a_type          = acq_deq.a_type;
  assign io_out_acquire_bits_union           = acq_deq.union_bits;
  assign io_out_acquire_bits_data            = acq_deq.data;

  assign io_in_grant_bits_addr_beat          = gnt_deq.addr_beat;
  assign io_in_grant_bits_client_xact_id     = gnt_deq.client_xact_id;
  assign io_in_grant_bits_manager_xact_id    = gnt_deq.manager_xact_id;
  assign io_in_grant_bits_is_builtin_type    = gnt_deq.is_builtin_type;
  assign io_in_grant_bits_g_type             = gnt_deq.g_type;
  assign io_in_grant_bits_data               = gnt_deq.data;

endmodule
